// File: rtl/compress_pkg.sv
// ============================================================================
// Module  : compress_pkg
// Brief   : Shared constants, types and helpers for the compress stream packer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package compress_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int NUM_UNITS  = 8;
  localparam int TAG_WIDTH  = 2;
  localparam int LEN_WIDTH  = 8;

  localparam int FLAG_VALID = 3;
  localparam int FLAG_TLAST = 2;
  localparam int FLAG_COMP  = 1;
  localparam int FLAG_HDR   = 0;

  localparam int BEAT_BITS  = DATA_WIDTH * NUM_UNITS;
  localparam int BEAT_BYTES = 32;
  localparam int TAG_BITS   = NUM_UNITS * TAG_WIDTH;
  localparam int TAG_BYTES  = 2;
  localparam int REC_BYTES  = BEAT_BYTES + TAG_BYTES;
  localparam int BUF_BYTES  = 96;
  localparam int FILL_W     = 7;

  localparam logic [FILL_W-1:0] FILL_BEAT      = FILL_W'(BEAT_BYTES);
  localparam logic [FILL_W-1:0] FILL_READY_MAX = FILL_W'(BUF_BYTES - REC_BYTES);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_FLUSH = 1'b1
  } packState_e;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + {5'd0, v[i]};
    return c;
  endfunction

  function automatic logic [31:0] satAdd32(input logic [31:0] a, input logic [FILL_W-1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {{(33-FILL_W){1'b0}}, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/byte_shift_merge.sv
// ============================================================================
// Module  : byte_shift_merge
// Brief   : Combinational barrel shifter placing a record at a byte offset
//           and OR-merging it into the accumulator image.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module byte_shift_merge
  import compress_pkg::*;
(
  input  logic [BUF_BYTES*8-1:0] accIn,
  input  logic [REC_BYTES*8-1:0] recIn,
  input  logic [FILL_W-1:0]      shiftBytes,
  output logic [BUF_BYTES*8-1:0] mergedOut
);

  logic [BUF_BYTES*8-1:0] w_recWide;

  // Bytes of the accumulator at and above the offset are always zero, so OR is a write.
  assign w_recWide = {{((BUF_BYTES-REC_BYTES)*8){1'b0}}, recIn};
  assign mergedOut = accIn | (w_recWide << {shiftBytes, 3'b000});

endmodule

`default_nettype wire

// File: rtl/compress_stream_packer.sv
// ============================================================================
// Module  : compress_stream_packer
// Brief   : Packs variable-length compress records into dense 256-bit beats
//           with keep/last; optional per-frame byte counters when
//           COMPRESS_PACKER_STATS_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module compress_stream_packer
  import compress_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             flags_in,
  input  logic [BEAT_BITS-1:0]   dataIn,
  input  logic [TAG_BITS-1:0]    tagIn,
  input  logic [LEN_WIDTH-1:0]   lenIn,
  output logic                   inReady,
  output logic [BEAT_BITS-1:0]   dataOut,
  output logic [BEAT_BYTES-1:0]  keepOut,
  output logic                   lastOut,
  output logic                   outValid,
  input  logic                   outReady,
  output logic                   errOut
`ifdef COMPRESS_PACKER_STATS_EN
  ,
  output logic [31:0]            statInBytes,
  output logic [31:0]            statOutBytes
`endif
);

  packState_e             r_state, w_nextState;
  logic [FILL_W-1:0]      r_fill, w_nextFill, w_fillAdd, w_recLen;
  logic [BUF_BYTES*8-1:0] r_acc, w_merged, w_appended, w_nextAcc;
  logic                   r_inReady, r_outValid, r_lastOut, r_err;
  logic [BEAT_BITS-1:0]   r_dataOut;
  logic [BEAT_BYTES-1:0]  r_keepOut, w_partKeep;
  logic [REC_BYTES*8-1:0] w_record;
  logic [5:0]             w_payLen;
  logic                   w_valid, w_tlast, w_isComp, w_lenBad, w_accept;
  logic                   w_beatAvail, w_load, w_final, w_nextInReady;

  assign w_valid  = flags_in[FLAG_VALID];
  assign w_tlast  = flags_in[FLAG_TLAST];
  assign w_isComp = flags_in[FLAG_COMP] && !flags_in[FLAG_HDR];
  assign w_lenBad = lenIn > LEN_WIDTH'(BEAT_BYTES);
  assign w_payLen = w_lenBad ? 6'(BEAT_BYTES) : lenIn[5:0];
  assign w_recLen = w_isComp ? (FILL_W'(w_payLen) + FILL_W'(TAG_BYTES)) : FILL_BEAT;
  assign w_accept = w_valid && r_inReady;

  // Compressed record: tag bytes first, then only the lenIn payload bytes (rest zeroed).
  always_comb begin
    w_record = '0;
    if (w_isComp) begin
      w_record[TAG_BITS-1:0] = tagIn;
      for (int k = 0; k < BEAT_BYTES; k++) begin
        if (6'(k) < w_payLen) w_record[8*(k+TAG_BYTES) +: 8] = dataIn[8*k +: 8];
      end
    end else begin
      w_record[BEAT_BITS-1:0] = dataIn;
    end
  end

  byte_shift_merge u_merge (
    .accIn      (r_acc),
    .recIn      (w_record),
    .shiftBytes (r_fill),
    .mergedOut  (w_merged)
  );

  assign w_final     = (r_state == ST_FLUSH) && (r_fill <= FILL_BEAT);
  assign w_beatAvail = (r_state == ST_ACCUM) ? (r_fill >= FILL_BEAT) : (r_fill != '0);
  assign w_load      = (!r_outValid || outReady) && w_beatAvail;
  assign w_appended  = w_accept ? w_merged : r_acc;
  assign w_nextAcc   = w_load ? (w_appended >> BEAT_BITS) : w_appended;
  assign w_fillAdd   = r_fill + (w_accept ? w_recLen : '0);
  assign w_partKeep  = ~({BEAT_BYTES{1'b1}} << r_fill);

  always_comb begin
    if (w_load && w_final)  w_nextFill = '0;
    else if (w_load)        w_nextFill = w_fillAdd - FILL_BEAT;
    else                    w_nextFill = w_fillAdd;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_ACCUM: if (w_accept && w_tlast) w_nextState = ST_FLUSH;
      ST_FLUSH: if ((w_load && w_final) || (r_fill == '0)) w_nextState = ST_ACCUM;
    endcase
  end

  assign w_nextInReady = (w_nextState == ST_ACCUM) && (w_nextFill <= FILL_READY_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_ACCUM;
      r_fill     <= '0;
      r_acc      <= '0;
      r_inReady  <= 1'b0;
      r_outValid <= 1'b0;
      r_dataOut  <= '0;
      r_keepOut  <= '0;
      r_lastOut  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_fill    <= w_nextFill;
      r_acc     <= w_nextAcc;
      r_inReady <= w_nextInReady;
      if (w_valid && (!r_inReady || (w_isComp && w_lenBad))) r_err <= 1'b1;
      if (w_load) begin
        r_outValid <= 1'b1;
        r_dataOut  <= r_acc[BEAT_BITS-1:0];
        r_keepOut  <= w_final ? w_partKeep : {BEAT_BYTES{1'b1}};
        r_lastOut  <= w_final;
      end else if (outReady) begin
        r_outValid <= 1'b0;
      end
    end
  end

  assign inReady  = r_inReady;
  assign dataOut  = r_dataOut;
  assign keepOut  = r_keepOut;
  assign lastOut  = r_lastOut;
  assign outValid = r_outValid;
  assign errOut   = r_err;

`ifdef COMPRESS_PACKER_STATS_EN
  logic [31:0] r_statIn, r_statOut;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_statIn  <= '0;
      r_statOut <= '0;
    end else if (r_outValid && outReady && r_lastOut) begin
      r_statIn  <= '0;
      r_statOut <= '0;
    end else begin
      if (w_accept) r_statIn <= satAdd32(r_statIn, w_recLen);
      if (r_outValid && outReady) r_statOut <= satAdd32(r_statOut, FILL_W'(popcount32(r_keepOut)));
    end
  end

  assign statInBytes  = r_statIn;
  assign statOutBytes = r_statOut;
`endif

endmodule

`default_nettype wire

// File: tb/tb_compress_stream_packer.sv
// ============================================================================
// Module  : tb_compress_stream_packer
// Brief   : Directed self-checking bench for compress_stream_packer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_compress_stream_packer;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   flags_in;
  logic [255:0] dataIn;
  logic [15:0]  tagIn;
  logic [7:0]   lenIn;
  logic         inReady;
  logic [255:0] dataOut;
  logic [31:0]  keepOut;
  logic         lastOut;
  logic         outValid;
  logic         outReady;
  logic         errOut;
`ifdef COMPRESS_PACKER_STATS_EN
  logic [31:0]  statInBytes, statOutBytes;
`endif

  int nCmp = 0;
  int nErr = 0;

  logic [255:0] qData[$];
  logic [31:0]  qKeep[$];
  logic         qLast[$];
  logic [7:0]   expStream[$];

  always #5 clk = ~clk;

  compress_stream_packer dut (
    .clk      (clk),
    .reset    (reset),
    .flags_in (flags_in),
    .dataIn   (dataIn),
    .tagIn    (tagIn),
    .lenIn    (lenIn),
    .inReady  (inReady),
    .dataOut  (dataOut),
    .keepOut  (keepOut),
    .lastOut  (lastOut),
    .outValid (outValid),
    .outReady (outReady),
    .errOut   (errOut)
`ifdef COMPRESS_PACKER_STATS_EN
    ,
    .statInBytes  (statInBytes),
    .statOutBytes (statOutBytes)
`endif
  );

  // Beats that will be handshaken on the coming rising edge.
  always @(negedge clk) begin
    if (!reset && outValid && outReady) begin
      qData.push_back(dataOut);
      qKeep.push_back(keepOut);
      qLast.push_back(lastOut);
    end
  end

  task automatic modelRecord(input logic [3:0] f, input logic [255:0] d, input logic [15:0] t, input logic [7:0] l);
    int n;
    if (f[1] && !f[0]) begin
      expStream.push_back(t[7:0]);
      expStream.push_back(t[15:8]);
      n = (l > 8'd32) ? 32 : int'(l);
    end else begin
      n = 32;
    end
    for (int k = 0; k < n; k++) expStream.push_back(d[8*k +: 8]);
  endtask

  function automatic int expBeats();
    return (expStream.size() + 31) / 32;
  endfunction

  function automatic logic [255:0] expData(input int b);
    logic [255:0] v;
    v = '0;
    for (int k = 0; k < 32; k++)
      if (b*32 + k < expStream.size()) v[8*k +: 8] = expStream[b*32 + k];
    return v;
  endfunction

  function automatic logic [31:0] expKeep(input int b);
    int rem;
    rem = expStream.size() - b*32;
    return (rem >= 32) ? 32'hFFFF_FFFF : ((32'd1 << rem) - 32'd1);
  endfunction

  task automatic clearAll();
    qData.delete(); qKeep.delete(); qLast.delete(); expStream.delete();
  endtask

  // Waits for inReady with valid low, then presents the group for exactly one accepting edge.
  task automatic drive(input logic [3:0] f, input logic [255:0] d, input logic [15:0] t,
                       input logic [7:0] l, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      ok = inReady;
    end
    if (ok) begin
      flags_in = f; dataIn = d; tagIn = t; lenIn = l;
      @(posedge clk); #1;
      flags_in = 4'b0000;
      modelRecord(f, d, t, l);
    end
  endtask

  task automatic waitFrame();
    for (int c = 0; c < 400 && qData.size() < expBeats(); c++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; outReady = 1'b1; flags_in = '0; dataIn = '0; tagIn = '0; lenIn = '0;
    #12;
    nCmp++; if (inReady !== 1'b0)  begin nErr++; $display("FAIL reset_inReady got %b want 0", inReady); end
    nCmp++; if (outValid !== 1'b0) begin nErr++; $display("FAIL reset_outValid got %b want 0", outValid); end
    nCmp++; if (keepOut !== 32'h0) begin nErr++; $display("FAIL reset_keep got %h want 0", keepOut); end
    nCmp++; if (lastOut !== 1'b0)  begin nErr++; $display("FAIL reset_last got %b want 0", lastOut); end
    nCmp++; if (dataOut !== 256'h0) begin nErr++; $display("FAIL reset_data got %h want 0", dataOut); end
    nCmp++; if (errOut !== 1'b0)   begin nErr++; $display("FAIL reset_err got %b want 0", errOut); end
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1;
    nCmp++; if (inReady !== 1'b1)  begin nErr++; $display("FAIL post_reset_inReady got %b want 1", inReady); end
  endtask

  task automatic test_raw();
    bit ok1, ok2;
    clearAll();
    drive(4'b1011, {8{32'hBA98FEDC}}, 16'h0, 8'd0, ok1);
    drive(4'b1111, {8{32'h01234567}}, 16'h0, 8'd0, ok2);
    waitFrame();
    nCmp++; if (!(ok1 && ok2)) begin nErr++; $display("FAIL raw_accept got %b%b want 11", ok1, ok2); end
    nCmp++; if (qData.size() !== 2) begin nErr++; $display("FAIL raw_beats got %0d want 2", qData.size()); end
    if (qData.size() == 2) begin
      nCmp++; if (qData[0] !== {8{32'hBA98FEDC}}) begin nErr++; $display("FAIL raw_data0 got %h want %h", qData[0], {8{32'hBA98FEDC}}); end
      nCmp++; if (qData[1] !== {8{32'h01234567}}) begin nErr++; $display("FAIL raw_data1 got %h want %h", qData[1], {8{32'h01234567}}); end
      nCmp++; if (qKeep[0] !== 32'hFFFFFFFF || qKeep[1] !== 32'hFFFFFFFF) begin nErr++; $display("FAIL raw_keep got %h %h want FFFFFFFF", qKeep[0], qKeep[1]); end
      nCmp++; if (qLast[0] !== 1'b0 || qLast[1] !== 1'b1) begin nErr++; $display("FAIL raw_last got %b%b want 01", qLast[0], qLast[1]); end
    end
  endtask

  task automatic test_compressed();
    bit ok, allOk;
    logic [255:0] d;
    clearAll();
    allOk = 1'b1;
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 32; j++) d[8*j +: 8] = (j < 14) ? 8'(k*16 + j) : 8'hEE;
      drive((k == 15) ? 4'b1110 : 4'b1010, d, {8'(8'hB0 + k), 8'(8'hA0 + k)}, 8'd14, ok);
      allOk = allOk && ok;
    end
    waitFrame();
    nCmp++; if (!allOk) begin nErr++; $display("FAIL comp_accept got 0 want 1"); end
    nCmp++; if (qData.size() !== 8) begin nErr++; $display("FAIL comp_beats got %0d want 8", qData.size()); end
    for (int b = 0; b < expBeats() && b < qData.size(); b++) begin
      nCmp++; if (qData[b] !== expData(b)) begin nErr++; $display("FAIL comp_data%0d got %h want %h", b, qData[b], expData(b)); end
      nCmp++; if (qKeep[b] !== expKeep(b)) begin nErr++; $display("FAIL comp_keep%0d got %h want %h", b, qKeep[b], expKeep(b)); end
      nCmp++; if (qLast[b] !== (b == 7)) begin nErr++; $display("FAIL comp_last%0d got %b want %b", b, qLast[b], (b == 7)); end
    end
  endtask

  task automatic test_partial();
    bit ok;
    clearAll();
    drive(4'b1110, {{29{8'hFF}}, 24'h332211}, 16'h5A5A, 8'd3, ok);
    waitFrame();
    nCmp++; if (qData.size() !== 1) begin nErr++; $display("FAIL part_beats got %0d want 1", qData.size()); end
    if (qData.size() == 1) begin
      nCmp++; if (qData[0] !== 256'h33_2211_5A5A) begin nErr++; $display("FAIL part_data got %h want %h", qData[0], 256'h332211_5A5A); end
      nCmp++; if (qKeep[0] !== 32'h0000001F) begin nErr++; $display("FAIL part_keep got %h want 0000001F", qKeep[0]); end
      nCmp++; if (qLast[0] !== 1'b1) begin nErr++; $display("FAIL part_last got %b want 1", qLast[0]); end
    end
    nCmp++; if (errOut !== 1'b0) begin nErr++; $display("FAIL part_err got %b want 0", errOut); end
  endtask

  task automatic fillBlocked(output bit allOk);
    bit ok;
    logic [255:0] d;
    allOk = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 32; j++) d[8*j +: 8] = 8'(k*40 + j + 1);
      drive(4'b1010, d, {8'(8'hD0 + k), 8'(8'hC0 + k)}, 8'd32, ok);
      allOk = allOk && ok;
    end
  endtask

  task automatic test_backpressure();
    bit ok, allOk;
    logic [255:0] d;
    clearAll();
    outReady = 1'b0;
    fillBlocked(allOk);
    repeat (5) @(negedge clk);
    nCmp++; if (inReady !== 1'b0) begin nErr++; $display("FAIL bp_inReady got %b want 0", inReady); end
    nCmp++; if (qData.size() !== 0) begin nErr++; $display("FAIL bp_no_handshake got %0d want 0", qData.size()); end
    nCmp++; if (outValid !== 1'b1) begin nErr++; $display("FAIL bp_outValid got %b want 1", outValid); end
    @(posedge clk); #1; outReady = 1'b1;
    for (int j = 0; j < 32; j++) d[8*j +: 8] = 8'(8'h90 + j);
    drive(4'b1110, d, 16'h7E7F, 8'd32, ok);
    waitFrame();
    nCmp++; if (!(allOk && ok)) begin nErr++; $display("FAIL bp_accept got 0 want 1"); end
    nCmp++; if (qData.size() !== 5) begin nErr++; $display("FAIL bp_beats got %0d want 5", qData.size()); end
    for (int b = 0; b < expBeats() && b < qData.size(); b++) begin
      nCmp++; if (qData[b] !== expData(b)) begin nErr++; $display("FAIL bp_data%0d got %h want %h", b, qData[b], expData(b)); end
      nCmp++; if (qKeep[b] !== expKeep(b)) begin nErr++; $display("FAIL bp_keep%0d got %h want %h", b, qKeep[b], expKeep(b)); end
      nCmp++; if (qLast[b] !== (b == 4)) begin nErr++; $display("FAIL bp_last%0d got %b want %b", b, qLast[b], (b == 4)); end
    end
    nCmp++; if (errOut !== 1'b0) begin nErr++; $display("FAIL bp_err got %b want 0", errOut); end
  endtask

  task automatic test_len_error();
    bit ok;
    logic [255:0] d;
    clearAll();
    for (int j = 0; j < 32; j++) d[8*j +: 8] = 8'(8'h40 + j);
    drive(4'b1110, d, 16'hC3C4, 8'd40, ok);
    waitFrame();
    nCmp++; if (errOut !== 1'b1) begin nErr++; $display("FAIL lenerr_err got %b want 1", errOut); end
    nCmp++; if (qData.size() !== 2) begin nErr++; $display("FAIL lenerr_beats got %0d want 2", qData.size()); end
    for (int b = 0; b < expBeats() && b < qData.size(); b++) begin
      nCmp++; if (qData[b] !== expData(b)) begin nErr++; $display("FAIL lenerr_data%0d got %h want %h", b, qData[b], expData(b)); end
      nCmp++; if (qKeep[b] !== expKeep(b)) begin nErr++; $display("FAIL lenerr_keep%0d got %h want %h", b, qKeep[b], expKeep(b)); end
      nCmp++; if (qLast[b] !== (b == 1)) begin nErr++; $display("FAIL lenerr_last%0d got %b want %b", b, qLast[b], (b == 1)); end
    end
  endtask

  task automatic test_async_reset();
    bit ok1, ok2, ok3, ok;
    clearAll();
    outReady = 1'b0;
    drive(4'b1011, {8{32'h11111111}}, 16'h0, 8'd0, ok1);
    drive(4'b1011, {8{32'h22222222}}, 16'h0, 8'd0, ok2);
    drive(4'b1111, {8{32'h33333333}}, 16'h0, 8'd0, ok3);
    #2 reset = 1'b1;
    #1;
    nCmp++; if (!(ok1 && ok2 && ok3)) begin nErr++; $display("FAIL ar_accept got 0 want 1"); end
    nCmp++; if (outValid !== 1'b0) begin nErr++; $display("FAIL ar_outValid got %b want 0", outValid); end
    nCmp++; if (dataOut !== 256'h0 || keepOut !== 32'h0 || lastOut !== 1'b0) begin nErr++; $display("FAIL ar_outputs got %h/%h/%b want 0/0/0", dataOut, keepOut, lastOut); end
    nCmp++; if (errOut !== 1'b0 || inReady !== 1'b0) begin nErr++; $display("FAIL ar_err_ready got %b/%b want 0/0", errOut, inReady); end
    @(posedge clk); #1; reset = 1'b0;
    clearAll();
    outReady = 1'b1;
    drive(4'b1110, {{29{8'h00}}, 24'hCCBBAA}, 16'h1234, 8'd3, ok);
    waitFrame();
    nCmp++; if (qData.size() !== 1) begin nErr++; $display("FAIL ar_beats got %0d want 1", qData.size()); end
    if (qData.size() == 1) begin
      nCmp++; if (qData[0] !== 256'hCCBBAA_1234) begin nErr++; $display("FAIL ar_data got %h want %h", qData[0], 256'hCCBBAA_1234); end
      nCmp++; if (qKeep[0] !== 32'h1F || qLast[0] !== 1'b1) begin nErr++; $display("FAIL ar_keep_last got %h/%b want 0000001F/1", qKeep[0], qLast[0]); end
    end
  endtask

  task automatic test_drop();
    bit ok, allOk;
    clearAll();
    outReady = 1'b0;
    fillBlocked(allOk);
    @(negedge clk);
    nCmp++; if (inReady !== 1'b0 || errOut !== 1'b0) begin nErr++; $display("FAIL drop_pre got %b/%b want 0/0", inReady, errOut); end
    flags_in = 4'b1010; dataIn = {32{8'hCC}}; tagIn = 16'hCCCC; lenIn = 8'd32;
    @(posedge clk); #1;
    flags_in = 4'b0000;
    @(negedge clk);
    nCmp++; if (errOut !== 1'b1) begin nErr++; $display("FAIL drop_err got %b want 1", errOut); end
    @(posedge clk); #1; outReady = 1'b1;
    drive(4'b1110, {{30{8'h00}}, 16'h6655}, 16'h4433, 8'd2, ok);
    waitFrame();
    nCmp++; if (!(allOk && ok)) begin nErr++; $display("FAIL drop_accept got 0 want 1"); end
    nCmp++; if (qData.size() !== 4) begin nErr++; $display("FAIL drop_beats got %0d want 4", qData.size()); end
    for (int b = 0; b < expBeats() && b < qData.size(); b++) begin
      nCmp++; if (qData[b] !== expData(b)) begin nErr++; $display("FAIL drop_data%0d got %h want %h", b, qData[b], expData(b)); end
      nCmp++; if (qKeep[b] !== expKeep(b)) begin nErr++; $display("FAIL drop_keep%0d got %h want %h", b, qKeep[b], expKeep(b)); end
      nCmp++; if (qLast[b] !== (b == 3)) begin nErr++; $display("FAIL drop_last%0d got %b want %b", b, qLast[b], (b == 3)); end
    end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_compressed();
    test_partial();
    test_backpressure();
    test_len_error();
    test_async_reset();
    test_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

`default_nettype wire
